// File: rtl/climate_scan_controller_if.sv
// Sensor/actuator/config bundle for climate_scan_controller.
//  master : controller side (drives smp_req/smp_room, actuator enables, status)
//  slave  : environment side (drives cfg_*, smp_ack/smp_data)
interface climate_scan_controller_if #(
  parameter int unsigned N_ROOMS = 4,
  parameter int unsigned TW      = 6
);
  localparam int unsigned RW = (N_ROOMS > 1) ? $clog2(N_ROOMS) : 1;

  logic               cfg_we;
  logic [TW-1:0]      cfg_hot;
  logic [TW-1:0]      cfg_cold;
  logic               cfg_err;
  logic               smp_req;
  logic [RW-1:0]      smp_room;
  logic               smp_ack;
  logic [TW-1:0]      smp_data;
  logic [N_ROOMS-1:0] heat_on;
  logic [N_ROOMS-1:0] cool_on;
  logic [N_ROOMS-1:0] fault;
  logic               alarm_hot;
  logic               alarm_cold;
  logic               busy;
  logic               overrun;

  modport master (
    input  cfg_we, cfg_hot, cfg_cold, smp_ack, smp_data,
    output cfg_err, smp_req, smp_room, heat_on, cool_on, fault,
           alarm_hot, alarm_cold, busy, overrun
  );

  modport slave (
    output cfg_we, cfg_hot, cfg_cold, smp_ack, smp_data,
    input  cfg_err, smp_req, smp_room, heat_on, cool_on, fault,
           alarm_hot, alarm_cold, busy, overrun
  );
endinterface

// File: rtl/climate_scan_controller.sv
// Periodic round-robin temperature scanner. Polls each room sensor over a
// req/ack port, filters out-of-band readings (confirmation count + hysteresis)
// and drives per-room heater/cooler enables plus global alarms.
// Ports:
//  clk  - system clock, rising edge
//  rst  - asynchronous active-low reset
//  bus  - climate_scan_controller_if.master: config write, sample req/ack,
//         heat_on/cool_on/fault vectors, alarm_hot/alarm_cold, busy, overrun
module climate_scan_controller #(
  parameter int unsigned N_ROOMS     = 4,
  parameter int unsigned TW          = 6,
  parameter int unsigned CONFIRM     = 3,
  parameter int unsigned HYST        = 1,
  parameter int unsigned SCAN_PERIOD = 1000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input logic                    clk,
  input logic                    rst,
  climate_scan_controller_if.master bus
);
  localparam int unsigned RW = (N_ROOMS > 1) ? $clog2(N_ROOMS) : 1;
  localparam int unsigned PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned AW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int unsigned CW = 4;
  localparam int unsigned XW = TW + 1;

  typedef enum logic [1:0] {IDLE, REQ, EVAL, NEXT} state_t;

  state_t             state;
  logic [RW-1:0]      room;
  logic [AW-1:0]      wait_cnt;
  logic [TW-1:0]      sample;
  logic               timed_out;
  logic [PW-1:0]      tick_cnt;
  logic               scan_pending;
  logic [TW-1:0]      thr_hot;
  logic [TW-1:0]      thr_cold;
  logic [CW-1:0]      cnt_h [N_ROOMS];
  logic [CW-1:0]      cnt_c [N_ROOMS];
  logic [N_ROOMS-1:0] heat_q;
  logic [N_ROOMS-1:0] cool_q;
  logic [N_ROOMS-1:0] fault_q;
  logic               smp_req_q;
  logic               cfg_err_q;
  logic               alarm_hot_q;
  logic               alarm_cold_q;
  logic               busy_q;
  logic               overrun_q;

  logic               tick_wrap;
  logic               scan_start;

  assign tick_wrap  = (tick_cnt == PW'(SCAN_PERIOD - 1));
  assign scan_start = (state == IDLE) && scan_pending;

  assign bus.cfg_err    = cfg_err_q;
  assign bus.smp_req    = smp_req_q;
  assign bus.smp_room   = room;
  assign bus.heat_on    = heat_q;
  assign bus.cool_on    = cool_q;
  assign bus.fault      = fault_q;
  assign bus.alarm_hot  = alarm_hot_q;
  assign bus.alarm_cold = alarm_cold_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

  // Next per-room state for the room under evaluation
  logic [XW-1:0]      d;
  logic               is_hot;
  logic               is_cold;
  logic [CW-1:0]      h_nx;
  logic [CW-1:0]      c_nx;
  logic [N_ROOMS-1:0] heat_vec_nx;
  logic [N_ROOMS-1:0] cool_vec_nx;

  always_comb begin
    d           = XW'(sample);
    is_hot      = d > XW'(thr_hot);
    is_cold     = d < XW'(thr_cold);
    h_nx        = cnt_h[room];
    c_nx        = cnt_c[room];
    heat_vec_nx = heat_q;
    cool_vec_nx = cool_q;
    if (timed_out) begin
      h_nx              = '0;
      c_nx              = '0;
      heat_vec_nx[room] = 1'b0;
      cool_vec_nx[room] = 1'b0;
    end else if (cool_q[room]) begin
      if (d + XW'(HYST) <= XW'(thr_hot)) cool_vec_nx[room] = 1'b0;
    end else if (heat_q[room]) begin
      if (d >= XW'(thr_cold) + XW'(HYST)) heat_vec_nx[room] = 1'b0;
    end else begin
      if (is_hot) begin
        h_nx = cnt_h[room] + CW'(1);
        c_nx = '0;
      end else if (is_cold) begin
        c_nx = cnt_c[room] + CW'(1);
        h_nx = '0;
      end else begin
        h_nx = '0;
        c_nx = '0;
      end
      if (h_nx == CW'(CONFIRM)) begin
        cool_vec_nx[room] = 1'b1;
        h_nx              = '0;
        c_nx              = '0;
      end else if (c_nx == CW'(CONFIRM)) begin
        heat_vec_nx[room] = 1'b1;
        h_nx              = '0;
        c_nx              = '0;
      end
    end
  end

  // Tick generator; at most one scan request is ever held pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt     <= '0;
      scan_pending <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tick_cnt  <= tick_wrap ? '0 : tick_cnt + PW'(1);
      overrun_q <= tick_wrap && scan_pending && !scan_start;
      if (tick_wrap)       scan_pending <= 1'b1;
      else if (scan_start) scan_pending <= 1'b0;
    end
  end

  // Scan FSM with registered outputs; thresholds only change while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      room         <= '0;
      wait_cnt     <= '0;
      sample       <= '0;
      timed_out    <= 1'b0;
      thr_hot      <= TW'(28);
      thr_cold     <= TW'(17);
      heat_q       <= '0;
      cool_q       <= '0;
      fault_q      <= '0;
      smp_req_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      alarm_hot_q  <= 1'b0;
      alarm_cold_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < int'(N_ROOMS); i++) begin
        cnt_h[i] <= '0;
        cnt_c[i] <= '0;
      end
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            if (bus.cfg_cold < bus.cfg_hot) begin
              thr_hot  <= bus.cfg_hot;
              thr_cold <= bus.cfg_cold;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          if (scan_start) begin
            state    <= REQ;
            room     <= '0;
            wait_cnt <= '0;
            busy_q   <= 1'b1;
          end
        end
        REQ: begin
          // Ack only counts once the request is visible on the port
          if (smp_req_q && bus.smp_ack) begin
            sample    <= bus.smp_data;
            timed_out <= 1'b0;
            smp_req_q <= 1'b0;
            state     <= EVAL;
          end else if (wait_cnt == AW'(ACK_TIMEOUT)) begin
            timed_out <= 1'b1;
            smp_req_q <= 1'b0;
            state     <= EVAL;
          end else begin
            wait_cnt  <= wait_cnt + AW'(1);
            smp_req_q <= 1'b1;
          end
        end
        EVAL: begin
          cnt_h[room]   <= h_nx;
          cnt_c[room]   <= c_nx;
          heat_q        <= heat_vec_nx;
          cool_q        <= cool_vec_nx;
          fault_q[room] <= timed_out;
          alarm_hot_q   <= |cool_vec_nx;
          alarm_cold_q  <= |heat_vec_nx;
          state         <= NEXT;
        end
        NEXT: begin
          if (room == RW'(N_ROOMS - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            room     <= room + RW'(1);
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_climate_scan_controller.sv
`timescale 1ns/1ps
module tb_climate_scan_controller;
  localparam int unsigned N_ROOMS = 4;
  localparam int unsigned TW      = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  climate_scan_controller_if #(.N_ROOMS(N_ROOMS), .TW(TW)) bus_main ();
  climate_scan_controller_if #(.N_ROOMS(N_ROOMS), .TW(TW)) bus_ovr ();

  climate_scan_controller #(
    .N_ROOMS(N_ROOMS), .TW(TW), .CONFIRM(3), .HYST(1),
    .SCAN_PERIOD(64), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_main)
  );

  // Long ack timeout so one unanswered scan outlasts two tick periods
  climate_scan_controller #(
    .N_ROOMS(N_ROOMS), .TW(TW), .CONFIRM(3), .HYST(1),
    .SCAN_PERIOD(64), .ACK_TIMEOUT(40)
  ) dut_ovr (
    .clk(clk),
    .rst(rst),
    .bus(bus_ovr)
  );

  int checks   = 0;
  int failures = 0;

  logic [TW-1:0]      room_temp [N_ROOMS];
  logic [N_ROOMS-1:0] ack_en;
  logic               main_ovr_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sensor model: one-cycle ack with the room's current temperature
  initial begin
    bus_main.smp_ack  = 1'b0;
    bus_main.smp_data = '0;
    forever begin
      @(negedge clk);
      if (bus_main.smp_req && ack_en[bus_main.smp_room] && !bus_main.smp_ack) begin
        bus_main.smp_ack  = 1'b1;
        bus_main.smp_data = room_temp[bus_main.smp_room];
      end else begin
        bus_main.smp_ack  = 1'b0;
      end
    end
  end

  always @(negedge clk) if (bus_main.overrun === 1'b1) main_ovr_seen = 1'b1;

  task automatic wait_busy(input logic level, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_main.busy === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_scan(input string tag);
    logic ok;
    wait_busy(1'b1, 200, ok);
    if (!ok) check_eq({tag, "_start"}, 32'(ok), 32'd1);
    wait_busy(1'b0, 200, ok);
    if (!ok) check_eq({tag, "_end"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [TW-1:0] seq3 [6];
  logic [3:0]    exp3 [6];
  logic          ok;
  logic          found;
  int            cnt;

  initial begin
    seq3 = '{6'd15, 6'd15, 6'd20, 6'd15, 6'd15, 6'd15};
    exp3 = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    rst = 1'b0;
    bus_main.cfg_we = 1'b0; bus_main.cfg_hot = '0; bus_main.cfg_cold = '0;
    bus_ovr.cfg_we  = 1'b0; bus_ovr.cfg_hot  = '0; bus_ovr.cfg_cold  = '0;
    bus_ovr.smp_ack = 1'b0; bus_ovr.smp_data = '0;
    ack_en = '1;
    for (int i = 0; i < int'(N_ROOMS); i++) room_temp[i] = 6'd22;

    repeat (3) @(negedge clk);
    check_eq("rst_heat",  32'(bus_main.heat_on), 32'd0);
    check_eq("rst_cool",  32'(bus_main.cool_on), 32'd0);
    check_eq("rst_fault", 32'(bus_main.fault), 32'd0);
    check_eq("rst_req",   32'(bus_main.smp_req), 32'd0);
    check_eq("rst_busy",  32'(bus_main.busy), 32'd0);
    check_eq("rst_alarm", 32'({bus_main.alarm_hot, bus_main.alarm_cold, bus_main.cfg_err, bus_main.overrun}), 32'd0);
    rst = 1'b1;

    // Room1 hot for three scans -> cooler on after third evaluation
    room_temp[1] = 6'd30;
    run_scan("t1_s1");
    check_eq("t1_scan1_cool", 32'(bus_main.cool_on), 32'd0);
    run_scan("t1_s2");
    check_eq("t1_scan2_cool", 32'(bus_main.cool_on), 32'd0);
    wait_busy(1'b1, 200, ok);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (bus_main.smp_ack === 1'b1 && bus_main.smp_room === 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t1_ack_seen", 32'(found), 32'd1);
    #1 check_eq("t1_cool_at_capture", 32'(bus_main.cool_on), 32'd0);
    @(posedge clk);
    #1 check_eq("t1_cool_after_eval", 32'(bus_main.cool_on), 32'b0010);
    check_eq("t1_alarm_hot", 32'(bus_main.alarm_hot), 32'd1);
    wait_busy(1'b0, 200, ok);

    // Hysteresis release of the cooler
    room_temp[1] = 6'd28;
    run_scan("t2_s1");
    check_eq("t2_cool_hold", 32'(bus_main.cool_on), 32'b0010);
    room_temp[1] = 6'd27;
    run_scan("t2_s2");
    check_eq("t2_cool_off", 32'(bus_main.cool_on), 32'd0);
    check_eq("t2_alarm_hot_off", 32'(bus_main.alarm_hot), 32'd0);
    room_temp[1] = 6'd22;

    // Broken cold streak on room2, then confirmed
    for (int k = 0; k < 6; k++) begin
      room_temp[2] = seq3[k];
      run_scan("t3");
      check_eq($sformatf("t3_heat_%0d", k), 32'(bus_main.heat_on), 32'(exp3[k]));
    end
    check_eq("t3_alarm_cold", 32'(bus_main.alarm_cold), 32'd1);

    // Room3 silent: 15-cycle request then fault
    ack_en[3] = 1'b0;
    wait_busy(1'b1, 200, ok);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_main.smp_req === 1'b1 && bus_main.smp_room === 2'd3) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t4_req_room3", 32'(found), 32'd1);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_main.smp_req === 1'b1) cnt++;
      else break;
    end
    check_eq("t4_req_cycles", 32'(cnt), 32'd15);
    wait_busy(1'b0, 200, ok);
    check_eq("t4_fault_set", 32'(bus_main.fault), 32'b1000);
    check_eq("t4_heat_kept", 32'(bus_main.heat_on), 32'b0100);
    wait_busy(1'b1, 200, ok);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_main.smp_req === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t4_next_room0", 32'({found, bus_main.smp_room}), 32'b100);
    ack_en[3] = 1'b1;
    wait_busy(1'b0, 200, ok);
    check_eq("t4_fault_clear", 32'(bus_main.fault), 32'd0);

    // Rejected config in idle; thresholds must remain 28/17
    @(negedge clk);
    bus_main.cfg_we = 1'b1; bus_main.cfg_hot = 6'd20; bus_main.cfg_cold = 6'd25;
    @(posedge clk);
    #1 check_eq("t5_err_pulse", 32'(bus_main.cfg_err), 32'd1);
    @(negedge clk);
    bus_main.cfg_we = 1'b0;
    @(posedge clk);
    #1 check_eq("t5_err_single", 32'(bus_main.cfg_err), 32'd0);
    room_temp[2] = 6'd19;
    run_scan("t5_s1");
    check_eq("t5_heat_release", 32'(bus_main.heat_on), 32'd0);

    // Writes while busy are dropped silently
    wait_busy(1'b1, 200, ok);
    bus_main.cfg_we = 1'b1; bus_main.cfg_hot = 6'd20; bus_main.cfg_cold = 6'd25;
    @(posedge clk);
    #1 check_eq("t5_busy_no_err", 32'(bus_main.cfg_err), 32'd0);
    @(negedge clk);
    bus_main.cfg_hot = 6'd21; bus_main.cfg_cold = 6'd10;
    @(negedge clk);
    bus_main.cfg_we = 1'b0;
    wait_busy(1'b0, 200, ok);
    room_temp[0] = 6'd25;
    room_temp[2] = 6'd22;
    repeat (3) run_scan("t5_ign");
    check_eq("t5_busy_write_ignored", 32'(bus_main.cool_on), 32'd0);

    // Valid idle write takes effect
    @(negedge clk);
    bus_main.cfg_we = 1'b1; bus_main.cfg_hot = 6'd24; bus_main.cfg_cold = 6'd10;
    @(posedge clk);
    #1 check_eq("t5_valid_no_err", 32'(bus_main.cfg_err), 32'd0);
    @(negedge clk);
    bus_main.cfg_we = 1'b0;
    run_scan("t5_v1");
    run_scan("t5_v2");
    check_eq("t5_new_thr_pending", 32'(bus_main.cool_on), 32'd0);
    run_scan("t5_v3");
    check_eq("t5_new_thr_cool", 32'(bus_main.cool_on), 32'b0001);

    // Asynchronous reset in the middle of a request
    wait_busy(1'b1, 200, ok);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_main.smp_req === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t6_req_seen", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t6_async_req",  32'(bus_main.smp_req), 32'd0);
    check_eq("t6_async_busy", 32'(bus_main.busy), 32'd0);
    check_eq("t6_async_cool", 32'({bus_main.cool_on, bus_main.alarm_hot}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_busy(1'b1, 50, ok);
    check_eq("t6_no_restart", 32'(ok), 32'd0);
    wait_busy(1'b1, 40, ok);
    check_eq("t6_restart_on_tick", 32'(ok), 32'd1);

    // Unanswered scans on the long-timeout instance overrun the tick
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_ovr.overrun === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t6_overrun_pulse", 32'(found), 32'd1);
    check_eq("t6_overrun_busy", 32'(bus_ovr.busy), 32'd1);
    @(negedge clk);
    check_eq("t6_overrun_single", 32'(bus_ovr.overrun), 32'd0);
    check_eq("t6_main_no_overrun", 32'(main_ovr_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
